// File: rtl/dsm_input_sequencer_if.sv
// dsm_input_sequencer_if: valid/ready stream of 20-bit signed samples into the sequencer
interface dsm_input_sequencer_if;
  logic s_valid;
  logic s_ready;
  logic [19:0] s_data;
  modport master (output s_valid, output s_data, input s_ready);
  modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dsm_input_sequencer.sv
// dsm_input_sequencer: FIFO-buffered sample feeder that linearly interpolates slow-rate samples into dsm_top vin
module dsm_input_sequencer #(
  parameter int OSR_LOG2 = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear_status,
  dsm_input_sequencer_if.slave s,
  output logic signed [19:0] vin,
  output logic dsm_run,
  output logic underflow,
  output logic [1:0] state,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int ACCW = 21 + OSR_LOG2;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] PRIME = (AW + 1)'(PRIME_LEVEL);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RAMP = 2'd2} state_t;
  state_t st, st_n;
  logic [19:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop, empty, boundary, uf_set;
  logic signed [19:0] head, tgt, tgt_n;
  logic signed [20:0] step, step_n;
  logic signed [ACCW-1:0] acc, acc_n;
  logic [OSR_LOG2-1:0] phase, phase_n;
  assign s.s_ready = cnt != FULL_LEVEL;
  assign push = s.s_valid && s.s_ready;
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign boundary = &phase;
  assign vin = acc[OSR_LOG2+19:OSR_LOG2];
  assign dsm_run = st != IDLE;
  assign state = st;
  assign fifo_level = cnt;
  always_ff @(posedge clock)
    if (push) mem[wp] <= s.s_data;
  always_ff @(posedge clock)
    if (!reset) begin
      st <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      acc <= '0;
      step <= '0;
      tgt <= '0;
      phase <= '0;
      underflow <= 1'b0;
    end else begin
      st <= st_n;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      acc <= acc_n;
      step <= step_n;
      tgt <= tgt_n;
      phase <= phase_n;
      underflow <= uf_set | (underflow & ~clear_status);
    end
  // boundary reload of acc from tgt keeps segment endpoints exact, so interpolation never drifts
  always_comb begin
    st_n = st;
    acc_n = acc;
    step_n = step;
    tgt_n = tgt;
    phase_n = phase;
    pop = 1'b0;
    uf_set = 1'b0;
    case (st)
      IDLE:
        if (enable && cnt >= PRIME) begin
          st_n = RUN;
          pop = 1'b1;
          tgt_n = head;
          step_n = {head[19], head};
          acc_n = '0;
          phase_n = '0;
        end
      default: begin
        phase_n = phase + 1'b1;
        acc_n = boundary ? {tgt[19], tgt, {OSR_LOG2{1'b0}}} : acc + {{OSR_LOG2{step[20]}}, step};
        if (boundary) begin
          if (st == RAMP) begin
            st_n = IDLE;
            acc_n = '0;
            step_n = '0;
          end else if (!enable) begin
            st_n = RAMP;
            step_n = -{tgt[19], tgt};
            tgt_n = '0;
          end else if (!empty) begin
            pop = 1'b1;
            step_n = {head[19], head} - {tgt[19], tgt};
            tgt_n = head;
          end else begin
            step_n = '0;
            uf_set = 1'b1;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_dsm_input_sequencer.sv
// tb_dsm_input_sequencer: directed plus randomized checks of the sequencer against a segment-level interpolation model
module tb_dsm_input_sequencer;
  localparam int L = 2, OSR = 4, DEPTH = 4, PRIME = 2;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, clear_status = 1'b0;
  logic signed [19:0] vin;
  logic dsm_run, underflow;
  logic [1:0] state;
  logic [2:0] fifo_level;
  int tests = 0, fails = 0;
  int m_q[$];
  int m_st = 0, m_prev = 0, m_tgt = 0, m_k = 0;
  bit m_uf = 1'b0;
  dsm_input_sequencer_if bus();
  dsm_input_sequencer #(.OSR_LOG2(L), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear_status(clear_status), .s(bus),
    .vin(vin), .dsm_run(dsm_run), .underflow(underflow), .state(state), .fifo_level(fifo_level));
  always #5 clock = ~clock;

  // model: each segment runs from m_prev to m_tgt in OSR steps; m_k counts steps taken
  task automatic model_step();
    bit pushok, set;
    if (!reset) begin
      m_q.delete(); m_st = 0; m_prev = 0; m_tgt = 0; m_k = 0; m_uf = 1'b0;
      return;
    end
    pushok = bus.s_valid && m_q.size() < DEPTH;
    set = 1'b0;
    if (m_st == 0) begin
      if (enable && m_q.size() >= PRIME) begin m_st = 1; m_prev = 0; m_tgt = m_q.pop_front(); m_k = 0; end
    end else begin
      m_k++;
      if (m_k == OSR) begin
        m_k = 0;
        m_prev = m_tgt;
        if (m_st == 2) m_st = 0;
        else if (!enable) begin m_st = 2; m_tgt = 0; end
        else if (m_q.size() != 0) m_tgt = m_q.pop_front();
        else set = 1'b1;
      end
    end
    m_uf = set | (m_uf & !clear_status);
    if (pushok) m_q.push_back(int'($signed(bus.s_data)));
  endtask

  function automatic int m_vin();
    int num, q;
    if (m_st == 0) return 0;
    num = m_prev * OSR + m_k * (m_tgt - m_prev);
    q = num / OSR;
    if (num % OSR != 0 && num < 0) q--;
    return q;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic push(input int v);
    bus.s_valid = 1'b1;
    bus.s_data = v[19:0];
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; clear_status = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tests++; if (int'(vin) !== 0) begin fails++; $display("FAIL reset_vin got %0d want 0", vin); end
    tests++; if (dsm_run !== 1'b0) begin fails++; $display("FAIL reset_run got %b want 0", dsm_run); end
    tests++; if (int'(state) !== 0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (int'(fifo_level) !== 0) begin fails++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow got %b want 0", underflow); end
    tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.s_ready); end
    reset = 1'b1;
  endtask

  task automatic test_ramp_up();
    do_reset();
    push(400); push(800);
    enable = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      tests++; if (int'(vin) !== 100 * i || dsm_run !== 1'b1) begin fails++; $display("FAIL ramp_up[%0d] vin=%0d run=%b want vin=%0d run=1", i, vin, dsm_run, 100 * i); end
    end
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL ramp_up_underflow got %b want 1", underflow); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (int'(vin) !== 800 || int'(state) !== 1) begin fails++; $display("FAIL hold[%0d] vin=%0d state=%0d want 800/1", i, vin, state); end
    end
  endtask

  task automatic test_stop();
    int n = 0;
    bit seen = 1'b0;
    enable = 1'b0;
    while (n < 8 && !seen) begin
      tick();
      n++;
      seen = int'(state) == 2;
      tests++; if (int'(vin) !== 800) begin fails++; $display("FAIL stop_finish[%0d] vin=%0d want 800", n, vin); end
    end
    tests++; if (!seen || n !== 2) begin fails++; $display("FAIL stop_to_ramp cycles=%0d reached=%b want 2/1", n, seen); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (int'(vin) !== 800 - 200 * i || int'(state) !== (i < 4 ? 2 : 0) || dsm_run !== (i < 4)) begin
        fails++; $display("FAIL ramp_down[%0d] vin=%0d state=%0d run=%b want %0d/%0d/%b", i, vin, state, dsm_run, 800 - 200 * i, i < 4 ? 2 : 0, i < 4);
      end
    end
  endtask

  task automatic test_floor();
    int exp_v[9] = '{0, -1, -2, -3, -3, -3, -3, -3, -3};
    do_reset();
    push(-3); push(-3);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      tests++; if (int'(vin) !== exp_v[i]) begin fails++; $display("FAIL floor[%0d] got %0d want %0d", i, vin, exp_v[i]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    push(11); push(22); push(33); push(44);
    tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", bus.s_ready); end
    tests++; if (int'(fifo_level) !== 4) begin fails++; $display("FAIL full_level got %0d want 4", fifo_level); end
    push(55);
    tests++; if (int'(fifo_level) !== 4) begin fails++; $display("FAIL full_refuse level got %0d want 4", fifo_level); end
    repeat (3) tick();
    tests++; if (int'(state) !== 0) begin fails++; $display("FAIL full_idle state got %0d want 0", state); end
    enable = 1'b1;
    tick();
    tests++; if (int'(state) !== 1 || int'(fifo_level) !== 3) begin fails++; $display("FAIL full_start state=%0d level=%0d want 1/3", state, fifo_level); end
    repeat (OSR) tick();
    tests++; if (int'(vin) !== 11) begin fails++; $display("FAIL full_first got %0d want 11", vin); end
    repeat (OSR) tick();
    tests++; if (int'(vin) !== 22) begin fails++; $display("FAIL full_second got %0d want 22", vin); end
    enable = 1'b0;
  endtask

  task automatic test_extremes();
    int prev;
    do_reset();
    push(524287); push(-524288);
    enable = 1'b1;
    tick();
    prev = int'(vin);
    for (int i = 1; i <= 8; i++) begin
      tick();
      tests++; if ((i <= 4) ? (int'(vin) <= prev) : (int'(vin) >= prev)) begin fails++; $display("FAIL extreme_mono[%0d] got %0d prev %0d", i, vin, prev); end
      if (i == 4) begin
        tests++; if (int'(vin) !== 524287) begin fails++; $display("FAIL extreme_max got %0d want 524287", vin); end
      end
      prev = int'(vin);
    end
    tests++; if (int'(vin) !== -524288) begin fails++; $display("FAIL extreme_min got %0d want -524288", vin); end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    push(100); push(200);
    enable = 1'b1;
    repeat (9) tick();
    push(300); push(400);
    tests++; if (underflow !== 1'b1 || int'(fifo_level) !== 2) begin fails++; $display("FAIL midrst_pre uf=%b level=%0d want 1/2", underflow, fifo_level); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    enable = 1'b0;
    tests++; if (int'(vin) !== 0 || dsm_run !== 1'b0 || int'(state) !== 0) begin fails++; $display("FAIL midrst_out vin=%0d run=%b state=%0d want 0/0/0", vin, dsm_run, state); end
    tests++; if (int'(fifo_level) !== 0 || underflow !== 1'b0) begin fails++; $display("FAIL midrst_status level=%0d uf=%b want 0/0", fifo_level, underflow); end
  endtask

  task automatic test_clear_vs_set();
    do_reset();
    push(100); push(200);
    enable = 1'b1;
    clear_status = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      tests++; if (underflow !== (i == 8)) begin fails++; $display("FAIL clear_set[%0d] got %b want %b", i, underflow, i == 8); end
    end
    clear_status = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_random();
    int dens = 4;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) dens = $urandom_range(8, 1);
      if ($urandom_range(39) == 0) enable = ~enable;
      bus.s_valid = $urandom_range(15) < dens;
      case ($urandom_range(3))
        0: bus.s_data = 20'h7FFFF;
        1: bus.s_data = 20'h80000;
        default: bus.s_data = 20'($urandom);
      endcase
      clear_status = $urandom_range(19) == 0;
      reset = $urandom_range(599) != 0;
      tick();
      tests++; if (int'(vin) !== m_vin()) begin fails++; $display("FAIL rnd_vin[%0d] got %0d want %0d", c, vin, m_vin()); end
      tests++; if (int'(state) !== m_st) begin fails++; $display("FAIL rnd_state[%0d] got %0d want %0d", c, state, m_st); end
      tests++; if (dsm_run !== (m_st != 0)) begin fails++; $display("FAIL rnd_run[%0d] got %b want %b", c, dsm_run, m_st != 0); end
      tests++; if (underflow !== m_uf) begin fails++; $display("FAIL rnd_underflow[%0d] got %b want %b", c, underflow, m_uf); end
      tests++; if (int'(fifo_level) !== m_q.size()) begin fails++; $display("FAIL rnd_level[%0d] got %0d want %0d", c, fifo_level, m_q.size()); end
      tests++; if (bus.s_ready !== (m_q.size() < DEPTH)) begin fails++; $display("FAIL rnd_ready[%0d] got %b want %b", c, bus.s_ready, m_q.size() < DEPTH); end
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    test_reset();
    test_ramp_up();
    test_stop();
    test_floor();
    test_fifo_full();
    test_extremes();
    test_reset_mid_run();
    test_clear_vs_set();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dsm_input_sequencer.md
Name: dsm_input_sequencer

Overview:
Feeds the delta-sigma modulator (dsm_top) from a slow-rate sample source. Accepts 20-bit signed samples over a valid/ready handshake into a small FIFO and pops one sample every OSR = 2^OSR_LOG2 fast clocks. Drives dsm_top vin with a linear interpolation between consecutive samples, and drives a run gate for the modulator. Sequences start-up from zero, graceful ramp-down to zero, and underflow hold.

Parameters:
OSR_LOG2, 6, log2 of oversampling ratio; segment length OSR = 2^OSR_LOG2 clocks (2 to 8 legal)
FIFO_DEPTH, 4, input FIFO entries (power of two, at least 2)
PRIME_LEVEL, 2, FIFO occupancy required before leaving IDLE (1 to FIFO_DEPTH)

Ports:
clock  in  1  fast modulator clock
reset  in  1  synchronous, active-low
enable  in  1  level; high requests streaming, low requests stop
s_valid  in  1  input sample valid
s_ready  out  1  FIFO can accept; equals !full
s_data  in  20  signed input sample
vin  out  20  signed interpolated sample to dsm_top
dsm_run  out  1  high while the modulator must run (RUN, RAMP)
underflow  out  1  sticky; set when a pop is due and the FIFO is empty
clear_status  in  1  clears underflow
state  out  2  IDLE=0, RUN=1, RAMP=2
fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (reset==0 at posedge clock) has priority over everything. Result: state=IDLE, FIFO empty, acc=0, cur=0, tgt=0, step=0, phase=0, vin=0, dsm_run=0, underflow=0, s_ready=1. Reset mid-stream discards FIFO contents; there is no ramp.
- Push: s_valid && s_ready writes s_data. s_ready depends only on full. At full, a push is refused even in a pop cycle.
- Internal registers: acc signed (21+OSR_LOG2) bits; step signed 21 bits; tgt signed 20 bits; phase OSR_LOG2 bits.
- vin = acc >>> OSR_LOG2, truncated to 20 bits. Arithmetic shift, floor rounding. vin is a direct register output with no added latency.
- IDLE: vin=0, dsm_run=0, phase held at 0.
  - Transition to RUN when enable && fifo_level >= PRIME_LEVEL.
  - On the transition: pop s; tgt<=s; step<=s-0; acc<=0; phase<=0.
- RUN: every cycle phase<=phase+1 (wraps) and acc<=acc+step, except at a boundary (phase==OSR-1), where acc<=tgt<<OSR_LOG2. The boundary value is exact, so no drift accumulates. Then at that boundary:
  - enable low: step<=0-tgt; tgt<=0; no pop; go to RAMP.
  - enable high, FIFO non-empty: pop s; step<=s-tgt; tgt<=s.
  - enable high, FIFO empty: step<=0; tgt unchanged (hold); underflow<=1; stay in RUN.
- A low enable is only sampled at a boundary; the current segment always completes.
- RAMP: same per-cycle update as RUN, ramping to 0. At the boundary: acc<=0, step<=0, go to IDLE; dsm_run falls on the same edge.
  - enable re-asserted during RAMP is ignored until IDLE is reached; IDLE restarts per the normal rules.
  - The FIFO is not flushed by stop.
- Pushes are accepted in all states.
- clear_status clears underflow. If clear_status and a set event occur in the same cycle, the set wins.
- Width rule: step is 21 bits (difference of two 20-bit values). acc always lies between consecutive samples scaled by OSR, so it never overflows.

Test Plan:
- OSR_LOG2=2. Push 400, 800; raise enable -> dsm_run=1 and vin=0,100,200,300,400,500,600,700,800 on consecutive cycles, then holds 800 with underflow=1.
- OSR_LOG2=2. Push -3, -3; enable -> vin=0,-1,-2,-3,-3 (floor rounding). Second segment holds at -3 with step 0.
- Stream running at 800; drop enable mid-segment -> segment completes, then vin=800,600,400,200,0. The state passes through RAMP to IDLE, and dsm_run=0 on the edge where vin reaches 0.
- Push FIFO_DEPTH samples with enable=0 -> s_ready=0, a fifth push is refused, fifo_level=4. Stay IDLE until enable rises; the first pop returns the first pushed value.
- Extremes: push 20'h7FFFF then 20'h80000 -> vin decreases monotonically from 524287 to -524288 with no wrap.
- Assert reset mid-RUN for one cycle -> next cycle vin=0, dsm_run=0, fifo_level=0, underflow=0, state=IDLE. Assert clear_status simultaneously with an underflow event -> underflow stays 1.
